// File: rtl/vga_linebuf_ctrl.sv
// VGA line-buffer controller for a 2x-scaled NES image.
// Schedules PPU line fills into a ping-pong line buffer and generates
// read enables/addresses for the visible 512x480 window.
module vga_linebuf_ctrl #(
    parameter logic [9:0] H_OFFSET = 10'd64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    output logic       fill_req,
    output logic [7:0] fill_line,
    output logic       fill_buf,
    input  logic       fill_ack,
    input  logic       fill_done,
    output logic       rd_en,
    output logic       rd_buf,
    output logic [7:0] rd_addr,
    output logic       pix_active,
    output logic       err,
    input  logic       err_clr
);

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    state_t      state_q, state_d;
    logic        fill_req_q, fill_req_d;
    logic [7:0]  fill_line_q, fill_line_d;
    logic        fill_buf_q, fill_buf_d;
    logic [1:0]  buf_valid_q, buf_valid_d;
    logic        line_ok_q, line_ok_d;
    logic        rd_en_q, rd_en_d;
    logic        rd_buf_q, rd_buf_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic        pix_active_q, pix_active_d;
    logic        err_q, err_d;

    logic        trig;
    logic [7:0]  trig_line;
    logic [9:0]  v_next;
    logic [9:0]  h_rel;
    logic        in_window;
    logic        err_set;
    logic        start;

    // Fill trigger decode: end of line on the rows that precede each NES line pair
    always_comb begin
        trig      = 1'b0;
        trig_line = '0;
        if (h_cnt == 10'd799) begin
            if (v_cnt == 10'd521) begin
                trig      = 1'b1;
                trig_line = 8'd0;
            end else if (v_cnt == 10'd523) begin
                trig      = 1'b1;
                trig_line = 8'd1;
            end else if (v_cnt[0] && (v_cnt <= 10'd475)) begin
                trig      = 1'b1;
                // v is odd here, so (v+3)/2 == (v>>1)+2
                trig_line = v_cnt[8:1] + 8'd2;
            end
        end
    end

    // Fill handshake FSM, buffer validity, line_ok latch and sticky error
    always_comb begin
        state_d     = state_q;
        fill_req_d  = fill_req_q;
        fill_line_d = fill_line_q;
        fill_buf_d  = fill_buf_q;
        buf_valid_d = buf_valid_q;
        line_ok_d   = line_ok_q;
        err_set     = 1'b0;
        start       = 1'b0;
        v_next      = (v_cnt == 10'd523) ? '0 : v_cnt + 10'd1;

        case (state_q)
            IDLE: begin
                if (fill_ack || fill_done) err_set = 1'b1;
                if (trig) start = 1'b1;
            end
            REQ: begin
                if (fill_done || trig) err_set = 1'b1;
                if (fill_ack) begin
                    fill_req_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (fill_ack) err_set = 1'b1;
                if (fill_done) begin
                    buf_valid_d[fill_buf_q] = 1'b1;
                    state_d = IDLE;
                    if (trig) start = 1'b1;
                end else if (trig) begin
                    err_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new fill invalidates its target buffer; it never aliases the one just completed
        if (start) begin
            fill_line_d = trig_line;
            fill_buf_d  = trig_line[0];
            fill_req_d  = 1'b1;
            buf_valid_d[trig_line[0]] = 1'b0;
            state_d     = REQ;
        end

        if (h_cnt == 10'd799) begin
            line_ok_d = buf_valid_q[v_next[1]];
            if ((v_next < 10'd480) && !buf_valid_q[v_next[1]]) err_set = 1'b1;
        end

        err_d = err_set | (err_q & ~err_clr);
    end

    // Read side: window decode, address generation and RAM-latency alignment
    always_comb begin
        h_rel        = h_cnt - H_OFFSET;
        in_window    = (h_rel < 10'd512);
        rd_en_d      = in_window && (v_cnt < 10'd480) && line_ok_q;
        rd_addr_d    = rd_addr_q;
        rd_buf_d     = rd_buf_q;
        if (rd_en_d) begin
            rd_addr_d = h_rel[8:1];
            rd_buf_d  = v_cnt[1];
        end
        pix_active_d = rd_en_q;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fill_req_q   <= 1'b0;
            fill_line_q  <= '0;
            fill_buf_q   <= 1'b0;
            buf_valid_q  <= '0;
            line_ok_q    <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_buf_q     <= 1'b0;
            rd_addr_q    <= '0;
            pix_active_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_req_q   <= fill_req_d;
            fill_line_q  <= fill_line_d;
            fill_buf_q   <= fill_buf_d;
            buf_valid_q  <= buf_valid_d;
            line_ok_q    <= line_ok_d;
            rd_en_q      <= rd_en_d;
            rd_buf_q     <= rd_buf_d;
            rd_addr_q    <= rd_addr_d;
            pix_active_q <= pix_active_d;
            err_q        <= err_d;
        end
    end

    assign fill_req   = fill_req_q;
    assign fill_line  = fill_line_q;
    assign fill_buf   = fill_buf_q;
    assign rd_en      = rd_en_q;
    assign rd_buf     = rd_buf_q;
    assign rd_addr    = rd_addr_q;
    assign pix_active = pix_active_q;
    assign err        = err_q;

endmodule

// File: tb/tb_vga_linebuf_ctrl.sv
// Testbench for vga_linebuf_ctrl: trigger table, directed scenarios and
// randomized handshakes against a transaction-level reference model.
module tb_vga_linebuf_ctrl;

    localparam int HO = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] h_cnt = '0;
    logic [9:0] v_cnt = '0;
    logic       fill_ack = 1'b0;
    logic       fill_done = 1'b0;
    logic       err_clr = 1'b0;
    logic       fill_req, fill_buf, rd_en, rd_buf, pix_active, err;
    logic [7:0] fill_line, rd_addr;

    vga_linebuf_ctrl #(.H_OFFSET(10'd64)) dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .fill_req(fill_req), .fill_line(fill_line), .fill_buf(fill_buf),
        .fill_ack(fill_ack), .fill_done(fill_done),
        .rd_en(rd_en), .rd_buf(rd_buf), .rd_addr(rd_addr),
        .pix_active(pix_active), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // compressed line: a few h positions around the window edges and the trigger column
    int HL[13] = '{0, 63, 64, 65, 66, 67, 300, 574, 575, 576, 577, 798, 799};

    // reference model: pending fill (line or -1), ack seen, buffer contents valid
    int m_txn, m_line, m_addr;
    bit m_acked, m_lok, m_err, m_rd, m_pix, m_rbuf;
    bit m_valid[2];

    // responder
    bit auto_resp = 0, hold_done = 0, rand_noise = 0, force_done = 0;
    int ack_dly = 1, done_dly = 8, r_phase = 0, r_cnt = 0;

    // observation logs
    int req_lines[$];
    int addr_log[$];
    int buf_log[$];
    bit prev_req = 0;
    int rd_cnt = 0, pix_cnt = 0, first_rd_h = -1, first_pix_h = -1;

    typedef struct {
        int v;
        int h;
        bit exp_req;
        int exp_line;
        bit exp_err;
    } tvec_t;
    tvec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (h=%0d v=%0d t=%0t)", name, act, exp, h_cnt, v_cnt, $time);
        end
    endtask

    function automatic int trig_of(input int hh, input int vv);
        if (hh != 799) return -1;
        if (vv == 521) return 0;
        if (vv == 523) return 1;
        if ((vv % 2 == 1) && vv <= 475) return (vv + 3) / 2;
        return -1;
    endfunction

    task automatic model_reset();
        m_txn = -1; m_line = 0; m_addr = 0; m_acked = 0;
        m_lok = 0; m_err = 0; m_rd = 0; m_pix = 0; m_rbuf = 0;
        m_valid[0] = 0; m_valid[1] = 0;
    endtask

    // one clock of the reference: uses the inputs about to be sampled
    task automatic model_step();
        int hh, vv, t, vn;
        bit set;
        hh = int'(h_cnt); vv = int'(v_cnt); t = trig_of(hh, vv); set = 0;
        m_pix = m_rd;
        m_rd = (hh >= HO) && (hh < HO + 512) && (vv < 480) && m_lok;
        if (m_rd) begin
            m_addr = (hh - HO) / 2;
            m_rbuf = ((vv / 2) % 2) == 1;
        end
        if (hh == 799) begin
            vn = (vv == 523) ? 0 : vv + 1;
            m_lok = m_valid[(vn / 2) % 2];
            if (vn < 480 && !m_lok) set = 1;
        end
        if (m_txn < 0) begin
            if (fill_ack || fill_done) set = 1;
            if (t >= 0) begin
                m_txn = t; m_line = t; m_acked = 0; m_valid[t % 2] = 0;
            end
        end else if (!m_acked) begin
            if (fill_done || t >= 0) set = 1;
            if (fill_ack) m_acked = 1;
        end else begin
            if (fill_ack) set = 1;
            if (fill_done) begin
                m_valid[m_txn % 2] = 1;
                m_txn = -1;
                if (t >= 0) begin
                    m_txn = t; m_line = t; m_acked = 0; m_valid[t % 2] = 0;
                end
            end else if (t >= 0) begin
                set = 1;
            end
        end
        m_err = set || (m_err && !err_clr);
    endtask

    task automatic check_all();
        chk("fill_req", 32'(fill_req), 32'(m_txn >= 0 && !m_acked));
        chk("fill_line", 32'(fill_line), 32'(m_line));
        chk("fill_buf", 32'(fill_buf), 32'(m_line % 2));
        chk("rd_en", 32'(rd_en), 32'(m_rd));
        chk("pix_active", 32'(pix_active), 32'(m_pix));
        chk("err", 32'(err), 32'(m_err));
        if (m_rd) begin
            chk("rd_addr", 32'(rd_addr), 32'(m_addr));
            chk("rd_buf", 32'(rd_buf), 32'(m_rbuf));
        end
    endtask

    task automatic drive_resp();
        if (auto_resp) begin
            fill_ack = 1'b0;
            fill_done = 1'b0;
            if (force_done) begin
                fill_done = 1'b1; r_phase = 0; force_done = 0;
            end else begin
                if (r_phase == 0 && fill_req === 1'b1) begin r_phase = 1; r_cnt = 0; end
                if (r_phase == 1) begin
                    if (r_cnt >= ack_dly) begin fill_ack = 1'b1; r_phase = 2; r_cnt = 0; end
                    else r_cnt++;
                end else if (r_phase == 2 && !hold_done) begin
                    r_cnt++;
                    if (r_cnt >= done_dly) begin fill_done = 1'b1; r_phase = 0; end
                end
            end
            if (rand_noise) begin
                if ($urandom_range(0, 59) == 0) fill_ack = 1'b1;
                if ($urandom_range(0, 59) == 0) fill_done = 1'b1;
                err_clr = ($urandom_range(0, 29) == 0);
            end
        end
    endtask

    task automatic cycle();
        drive_resp();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        if (fill_req === 1'b1 && !prev_req) req_lines.push_back(int'(fill_line));
        prev_req = (fill_req === 1'b1);
        if (rd_en === 1'b1) begin
            rd_cnt++;
            addr_log.push_back(int'(rd_addr));
            buf_log.push_back(int'(rd_buf));
            if (first_rd_h < 0) first_rd_h = int'(h_cnt);
        end
        if (pix_active === 1'b1) begin
            pix_cnt++;
            if (first_pix_h < 0) first_pix_h = int'(h_cnt);
        end
    endtask

    task automatic clear_logs();
        req_lines.delete(); addr_log.delete(); buf_log.delete();
        rd_cnt = 0; pix_cnt = 0; first_rd_h = -1; first_pix_h = -1;
    endtask

    task automatic run_line(input int vv, input bit full);
        v_cnt = 10'(vv);
        if (full) begin
            for (int hh = 0; hh < 800; hh++) begin h_cnt = 10'(hh); cycle(); end
        end else begin
            if (rand_noise) begin h_cnt = 10'($urandom_range(0, 798)); cycle(); end
            for (int i = 0; i < 13; i++) begin h_cnt = 10'(HL[i]); cycle(); end
        end
    endtask

    // asynchronous reset asserted between clock edges
    task automatic do_reset();
        #2 rst = 1'b0;
        fill_ack = 1'b0; fill_done = 1'b0; err_clr = 1'b0;
        #1;
        chk("rst_fill_req", 32'(fill_req), 32'd0);
        chk("rst_fill_line", 32'(fill_line), 32'd0);
        chk("rst_fill_buf", 32'(fill_buf), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_buf", 32'(rd_buf), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_pix", 32'(pix_active), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        model_reset();
        r_phase = 0; prev_req = 0; force_done = 0;
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    initial begin
        int n;
        tbl[0]  = '{521, 799, 1'b1, 0,   1'b0};
        tbl[1]  = '{523, 799, 1'b1, 1,   1'b1};
        tbl[2]  = '{1,   799, 1'b1, 2,   1'b1};
        tbl[3]  = '{3,   799, 1'b1, 3,   1'b1};
        tbl[4]  = '{475, 799, 1'b1, 239, 1'b1};
        tbl[5]  = '{239, 799, 1'b1, 121, 1'b1};
        tbl[6]  = '{477, 799, 1'b0, 0,   1'b1};
        tbl[7]  = '{0,   799, 1'b0, 0,   1'b1};
        tbl[8]  = '{522, 799, 1'b0, 0,   1'b0};
        tbl[9]  = '{2,   799, 1'b0, 0,   1'b1};
        tbl[10] = '{479, 799, 1'b0, 0,   1'b0};
        tbl[11] = '{521, 798, 1'b0, 0,   1'b0};

        model_reset();

        // trigger decode table, each entry from a fresh reset
        auto_resp = 0;
        for (int i = 0; i < 12; i++) begin
            do_reset();
            h_cnt = 10'(tbl[i].h); v_cnt = 10'(tbl[i].v);
            cycle();
            chk("tbl_req", 32'(fill_req), 32'(tbl[i].exp_req));
            chk("tbl_line", 32'(fill_line), 32'(tbl[i].exp_line));
            chk("tbl_buf", 32'(fill_buf), 32'(tbl[i].exp_line % 2));
            chk("tbl_err", 32'(err), 32'(tbl[i].exp_err));
            h_cnt = 10'd0;
            cycle();
            chk("tbl_req_hold", 32'(fill_req), 32'(tbl[i].exp_req));
        end

        // first line after reset: slow responder, full-resolution lines
        auto_resp = 1; ack_dly = 3; done_dly = 200; hold_done = 0;
        h_cnt = 10'd5; v_cnt = 10'd300;
        do_reset();
        clear_logs();
        run_line(521, 1);
        chk("s1_req", 32'(fill_req), 32'd1);
        chk("s1_line", 32'(fill_line), 32'd0);
        chk("s1_buf", 32'(fill_buf), 32'd0);
        clear_logs();
        run_line(522, 1);
        run_line(523, 1);
        chk("s1_blank_rd", 32'(rd_cnt), 32'd0);
        clear_logs();
        run_line(0, 1);
        chk("s1_rd_cnt", 32'(rd_cnt), 32'd512);
        chk("s1_pix_cnt", 32'(pix_cnt), 32'd512);
        chk("s1_first_rd_h", 32'(first_rd_h), 32'(HO));
        chk("s1_first_pix_h", 32'(first_pix_h), 32'(HO + 1));
        for (int i = 0; i < addr_log.size() && i < 512; i++) begin
            chk("s1_addr", 32'(addr_log[i]), 32'(i / 2));
            chk("s1_rbuf", 32'(buf_log[i]), 32'd0);
        end

        // full compressed frame with a prompt responder
        ack_dly = 1; done_dly = 8;
        h_cnt = 10'd0; v_cnt = 10'd520;
        do_reset();
        clear_logs();
        for (int vv = 520; vv < 524; vv++) run_line(vv, 0);
        for (int vv = 0; vv < 520; vv++) run_line(vv, 0);
        chk("s2_req_cnt", 32'(req_lines.size()), 32'd240);
        for (int i = 0; i < req_lines.size() && i < 240; i++)
            chk("s2_req_line", 32'(req_lines[i]), 32'(i));
        chk("s2_rd_cnt", 32'(rd_cnt), 32'(480 * 7));
        chk("s2_err", 32'(err), 32'd0);

        // line 5 fill withheld past the v=9 trigger
        h_cnt = 10'd0; v_cnt = 10'd520;
        do_reset();
        clear_logs();
        for (int vv = 520; vv < 524; vv++) run_line(vv, 0);
        for (int vv = 0; vv < 7; vv++) run_line(vv, 0);
        hold_done = 1;
        for (int vv = 7; vv < 10; vv++) run_line(vv, 0);
        chk("s3_err", 32'(err), 32'd1);
        chk("s3_req_dropped", 32'(fill_req), 32'd0);
        rd_cnt = 0;
        run_line(10, 0);
        run_line(11, 0);
        chk("s3_no_rd", 32'(rd_cnt), 32'd0);
        hold_done = 0;
        for (int vv = 12; vv < 20; vv++) run_line(vv, 0);
        n = 0;
        foreach (req_lines[i]) if (req_lines[i] == 6) n++;
        chk("s3_line6_never", 32'(n), 32'd0);
        n = 0;
        foreach (req_lines[i]) if (req_lines[i] == 5) n++;
        chk("s3_line5_once", 32'(n), 32'd1);

        // fill_done coinciding with the next trigger
        h_cnt = 10'd0; v_cnt = 10'd474;
        do_reset();
        hold_done = 1;
        for (int vv = 474; vv < 500; vv++) run_line(vv, 0);
        auto_resp = 0;
        fill_ack = 0; fill_done = 0; err_clr = 1'b1;
        h_cnt = 10'd0; v_cnt = 10'd500;
        cycle();
        err_clr = 1'b0;
        chk("s4_clr", 32'(err), 32'd0);
        auto_resp = 1;
        for (int vv = 500; vv < 521; vv++) run_line(vv, 0);
        v_cnt = 10'd521;
        for (int i = 0; i < 12; i++) begin h_cnt = 10'(HL[i]); cycle(); end
        force_done = 1;
        h_cnt = 10'd799;
        cycle();
        chk("s4_new_req", 32'(fill_req), 32'd1);
        chk("s4_new_line", 32'(fill_line), 32'd0);
        chk("s4_err", 32'(err), 32'd0);
        hold_done = 0;
        for (int vv = 522; vv < 524; vv++) run_line(vv, 0);

        // spurious ack in IDLE with err_clr in the same cycle
        h_cnt = 10'd100; v_cnt = 10'd10;
        do_reset();
        auto_resp = 0;
        fill_ack = 1'b1; err_clr = 1'b1;
        cycle();
        fill_ack = 1'b0; err_clr = 1'b0;
        chk("s5_set_wins", 32'(err), 32'd1);
        cycle();
        chk("s5_sticky", 32'(err), 32'd1);
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("s5_cleared", 32'(err), 32'd0);

        // reset during BUSY, then a late fill_done
        h_cnt = 10'd0; v_cnt = 10'd523;
        do_reset();
        auto_resp = 1; ack_dly = 0; hold_done = 1;
        h_cnt = 10'd799;
        cycle();
        h_cnt = 10'd0; v_cnt = 10'd0;
        for (int i = 0; i < 3; i++) cycle();
        chk("s6_busy_line", 32'(fill_line), 32'd1);
        chk("s6_busy_buf", 32'(fill_buf), 32'd1);
        do_reset();
        auto_resp = 0; hold_done = 0;
        fill_done = 1'b1; h_cnt = 10'd5;
        cycle();
        fill_done = 1'b0;
        chk("s6_late_done", 32'(err), 32'd1);

        // randomized handshakes over compressed frames
        h_cnt = 10'd0; v_cnt = 10'd0;
        do_reset();
        auto_resp = 1; rand_noise = 1;
        for (int f = 0; f < 4; f++) begin
            int rst_v;
            ack_dly = int'($urandom_range(0, 3));
            done_dly = int'($urandom_range(0, 35));
            rst_v = (f == 2) ? int'($urandom_range(0, 523)) : -1;
            for (int vv = 0; vv < 524; vv++) begin
                if (vv == rst_v) do_reset();
                run_line(vv, 0);
            end
        end
        rand_noise = 0; auto_resp = 0;
        fill_ack = 0; fill_done = 0; err_clr = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_linebuf_ctrl.md
VGA_LINEBUF_CTRL -- requirements
Module: vga_linebuf_ctrl

Interface
REQ-001 The block SHALL have the parameter H_OFFSET, default 10'd64, giving the first visible h_cnt of the 512-pixel doubled NES image.
REQ-002 The block SHALL have these ports, with exactly one clock, and reset asynchronous and active-low:
 clk  in  1  pixel clock
 rst  in  1  asynchronous active-low reset
 h_cnt  in  10  VGA x position, 0..799
 v_cnt  in  10  VGA y position, 0..523
 fill_req  out  1  fill request to the PPU line renderer
 fill_line  out  8  NES line to render, 0..239
 fill_buf  out  1  ping-pong buffer to write
 fill_ack  in  1  single-cycle request accept
 fill_done  in  1  single-cycle fill complete
 rd_en  out  1  line-buffer read enable
 rd_buf  out  1  line buffer being read
 rd_addr  out  8  line-buffer read address
 pix_active  out  1  image pixel valid, aligned with 1-cycle RAM data
 err  out  1  sticky scheduling error
 err_clr  in  1  synchronous clear of err

Function
REQ-003 The trigger SHALL be h_cnt==799 with v_cnt==521 (line 0), v_cnt==523 (line 1), or v_cnt odd in 1..475 (line (v_cnt+3)/2).
REQ-004 fill_buf SHALL equal fill_line[0].
REQ-005 The FSM SHALL have states IDLE, REQ and BUSY.
REQ-006 On a trigger in IDLE, the FSM SHALL register fill_line/fill_buf, assert fill_req the next cycle, clear buf_valid[fill_buf], and enter REQ.
REQ-007 REQ SHALL hold fill_req, fill_line and fill_buf stable until fill_ack; on fill_ack it SHALL deassert fill_req the next cycle and enter BUSY.
REQ-008 BUSY SHALL set buf_valid[fill_buf] on fill_done and return to IDLE.
REQ-009 In BUSY, fill_done and a trigger in the same cycle SHALL complete the old fill and then immediately start the new one (enter REQ).
REQ-010 A trigger arriving in REQ, or in BUSY without fill_done, SHALL be dropped and SHALL set err; the current transaction continues.
REQ-011 fill_ack outside REQ and fill_done outside BUSY SHALL be ignored and SHALL set err.
REQ-012 At h_cnt==799, line_ok SHALL be latched as buf_valid[v_next[1]] for the next line, where v_next=(v_cnt==523)?0:v_cnt+1.
REQ-013 If the next line is <480 and line_ok would be 0, err SHALL be set.
REQ-014 rd_en SHALL be registered and assert one cycle after h_cnt is in H_OFFSET..H_OFFSET+511, while v_cnt<480 and line_ok=1.
REQ-015 With rd_en, rd_addr SHALL be registered as (h_cnt-H_OFFSET)>>1 (10-bit subtract, bits [8:1]), and rd_buf SHALL be v_cnt[1].
REQ-016 pix_active SHALL be rd_en delayed by one cycle.
REQ-017 The total latency from h_cnt to pix_active SHALL be 2 cycles.
REQ-018 err SHALL hold until err_clr; if err_clr and a set event occur in the same cycle, the set SHALL win.

Reset
REQ-019 While rst=0, state SHALL be IDLE; fill_req, fill_line, fill_buf, rd_en, rd_buf, rd_addr, pix_active, err, buf_valid and line_ok SHALL all be 0.
REQ-020 Reset asserted mid-transaction SHALL abort the transaction immediately.
REQ-021 After reset release, the first trigger SHALL be the next qualifying one, with no catch-up requests.

Verification
REQ-022 Scenario: reset, run to v=521, h=799, ack after 3 cycles, done after 200 cycles -> fill_req rises for line 0/buf 0; rd_en is 0 on lines 522-523; line 0 reads 0,0,1,1..255,255 on buf 0; pix_active lags 2 cycles.
REQ-023 Scenario: full frame, ideal responder -> 240 requests (lines 0..239); buffer alternates; err stays 0; v=2n and v=2n+1 both read buf n&1.
REQ-024 Scenario: withhold fill_done for line 5 past v=9, h=799 -> err=1; no rd_en on v=10-11; the trigger at v=9 is dropped.
REQ-025 Scenario: fill_done and trigger in the same cycle -> buf_valid set; new fill_req the next cycle; err=0.
REQ-026 Scenario: spurious fill_ack in IDLE with err_clr high the same cycle -> err=1.
REQ-027 Scenario: rst low during BUSY -> all outputs 0 asynchronously; a late fill_done after release sets err.
